// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master: FSM state codes, bus word
// size and the user-project register/memory map used by bench and software.
package wb_host_pkg;

  // Bytes advanced per beat on the Wishbone address bus
  localparam int WB_WORD_BYTES = 4;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WDAT = 2'd1;
  localparam logic [1:0] ST_BUS  = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  // User-project address map (byte addresses)
  localparam logic [31:0] ADDR_MODE     = 32'h3000_0000;
  localparam logic [31:0] ADDR_DEBUG    = 32'h3000_0004;
  localparam logic [31:0] ADDR_QP_MEM   = 32'h3000_1000;
  localparam logic [31:0] ADDR_LEAF_MEM = 32'h3000_2000;
  localparam logic [31:0] ADDR_NODE_MEM = 32'h3000_3000;
  localparam logic [31:0] ADDR_BEST_ARR = 32'h3000_4000;

endpackage

// File: rtl/wb_host_master.sv
// Wishbone classic-cycle initiator. Takes burst commands on a valid/ready
// stream, issues one single-beat transfer per word (address +4 per beat),
// and returns read words or a single write completion on the response stream.
// A per-beat watchdog aborts the command if the slave stops acknowledging.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [3:0]        cmd_sel,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              busy
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort fires on the TIMEOUT-th strobe cycle, so stb is high exactly TIMEOUT cycles
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [3:0]        r_sel;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_cyc;
  logic              r_stb;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat_o;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_rsp_last;

  logic [LEN_W-1:0]  w_beat_inc;
  logic [ADDR_W-1:0] w_adr_cur;
  logic [ADDR_W-1:0] w_adr_next;
  logic              w_last_beat;

  // Beat addresses are base + 4*beat, wrapping naturally at 2^ADDR_W
  assign w_beat_inc  = r_beat + 1'b1;
  assign w_adr_cur   = r_base + ADDR_W'(r_beat) * ADDR_W'(WB_WORD_BYTES);
  assign w_adr_next  = r_base + ADDR_W'(w_beat_inc) * ADDR_W'(WB_WORD_BYTES);
  assign w_last_beat = (r_beat == r_len);

  // Command sequencing, bus drive and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_sel      <= '0;
      r_tmo      <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_adr      <= '0;
      r_dat_o    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_last <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_we       <= cmd_we;
            r_base     <= cmd_addr;
            r_len      <= cmd_len;
            r_sel      <= cmd_sel;
            r_beat     <= '0;
            r_tmo      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_last <= 1'b0;
            if (cmd_we) begin
              r_state <= ST_WDAT;
            end else begin
              r_state <= ST_BUS;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_adr   <= cmd_addr;
            end
          end
        end
        ST_WDAT: begin
          // cyc is left as-is so it stays asserted across write beats
          if (wdata_valid) begin
            r_dat_o <= wdata;
            r_state <= ST_BUS;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_adr   <= w_adr_cur;
            r_tmo   <= '0;
          end
        end
        ST_BUS: begin
          if (r_stb && wbm_ack_i) begin
            r_stb <= 1'b0;
            r_tmo <= '0;
            if (!r_we) begin
              r_rsp_data <= wbm_dat_i;
              r_rsp_last <= w_last_beat;
              r_cyc      <= !w_last_beat;
              r_state    <= ST_RSP;
            end else if (!w_last_beat) begin
              r_beat  <= w_beat_inc;
              r_state <= ST_WDAT;
            end else begin
              r_rsp_data <= '0;
              r_rsp_last <= 1'b1;
              r_cyc      <= 1'b0;
              r_state    <= ST_RSP;
            end
          end else if (r_tmo == TMO_LIMIT) begin
            // Slave went silent: abandon the rest of the burst
            r_stb      <= 1'b0;
            r_cyc      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_rsp_last <= 1'b1;
            r_state    <= ST_RSP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            if (r_rsp_last) begin
              r_state <= ST_IDLE;
              r_cyc   <= 1'b0;
            end else begin
              r_beat <= w_beat_inc;
              r_tmo  <= '0;
              if (r_we) begin
                r_state <= ST_WDAT;
              end else begin
                r_state <= ST_BUS;
                r_stb   <= 1'b1;
                r_adr   <= w_adr_next;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign wdata_ready = (r_state == ST_WDAT);
  assign rsp_valid   = (r_state == ST_RSP);
  assign busy        = (r_state != ST_IDLE);
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign rsp_last    = r_rsp_last;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_stb;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat_o;

endmodule
